alu_reg_file: RTL and testbench

Eight-entry, 16-bit register file sitting directly around the ALU datapath: its two registered read ports drive the ALU A and B operands, and its write port captures the ALU result S on write-back. It also holds the ALU status flags (Zero, Overflow, sticky Overflow) so the control sequencer can test them. One read cycle plus one ALU evaluation forms the operand→result loop.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_reg_file_if.sv | 32 +++
 rtl/alu_status_flags.sv | 30 +++
 rtl/alu_reg_file.sv | 56 +++++
 tb/tb_alu_reg_file.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared datapath constants and ALU_Control opcodes
package alu_pkg;

    localparam int WIDTH    = 16;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    // Opcode values are shared with the ALU and the control sequencer.
    typedef enum logic [3:0] {
        ALU_SUB = 4'b0000,
        ALU_ADD = 4'b0001,
        ALU_OR  = 4'b0010,
        ALU_AND = 4'b0011,
        ALU_DEC = 4'b0100,
        ALU_INC = 4'b0101,
        ALU_INV = 4'b0110,
        ALU_LSL = 4'b1000,
        ALU_SLE = 4'b1001,
        ALU_LSR = 4'b1010,
        ALU_ASL = 4'b1100,
        ALU_ASR = 4'b1110
    } alu_control_e;

endpackage

// File: rtl/alu_reg_file_if.sv
// rtl/alu_reg_file_if.sv - register file / flag bus between sequencer (master) and register file (slave)
interface alu_reg_file_if;
    import alu_pkg::*;

    logic              RegWrite;
    logic [ADDR_W-1:0] WriteAddr;
    logic [WIDTH-1:0]  WriteData;
    logic [ADDR_W-1:0] ReadAddrA;
    logic [ADDR_W-1:0] ReadAddrB;
    logic [WIDTH-1:0]  ReadDataA;
    logic [WIDTH-1:0]  ReadDataB;
    logic              FlagWrite;
    logic              OverflowIn;
    logic              ZeroIn;
    logic              FlagClear;
    logic              FlagZero;
    logic              FlagOverflow;
    logic              FlagOverflowSticky;

    modport master (
        output RegWrite, WriteAddr, WriteData, ReadAddrA, ReadAddrB,
        output FlagWrite, OverflowIn, ZeroIn, FlagClear,
        input  ReadDataA, ReadDataB, FlagZero, FlagOverflow, FlagOverflowSticky
    );

    modport slave (
        input  RegWrite, WriteAddr, WriteData, ReadAddrA, ReadAddrB,
        input  FlagWrite, OverflowIn, ZeroIn, FlagClear,
        output ReadDataA, ReadDataB, FlagZero, FlagOverflow, FlagOverflowSticky
    );

endinterface

// File: rtl/alu_status_flags.sv
// rtl/alu_status_flags.sv - ALU Zero/Overflow capture registers with sticky overflow
module alu_status_flags (
    input  logic clk,
    input  logic reset,
    input  logic flag_write,
    input  logic overflow_in,
    input  logic zero_in,
    input  logic flag_clear,
    output logic flag_zero,
    output logic flag_overflow,
    output logic flag_overflow_sticky
);

    always_ff @(posedge clk) begin
        if (reset) begin
            flag_zero            <= 1'b0;
            flag_overflow        <= 1'b0;
            flag_overflow_sticky <= 1'b0;
        end else begin
            if (flag_write) begin
                flag_zero     <= zero_in;
                flag_overflow <= overflow_in;
            end
            // A new overflow outranks a clear arriving in the same cycle.
            flag_overflow_sticky <= (flag_overflow_sticky & ~flag_clear)
                                  | (flag_write & overflow_in);
        end
    end

endmodule

// File: rtl/alu_reg_file.sv
// rtl/alu_reg_file.sv - 8x16 register file with registered ALU operand ports; ALU_REGFILE_BYPASS_EN enables write-to-read forwarding
module alu_reg_file
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    alu_reg_file_if.slave bus
);

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic [WIDTH-1:0] read_a_q, read_b_q;
    logic [WIDTH-1:0] next_a, next_b;
    logic             write_en;

    assign write_en = bus.RegWrite && (bus.WriteAddr != '0);

    always_comb begin
        next_a = regs[bus.ReadAddrA];
        next_b = regs[bus.ReadAddrB];
`ifdef ALU_REGFILE_BYPASS_EN
        if (write_en && (bus.WriteAddr == bus.ReadAddrA)) next_a = bus.WriteData;
        if (write_en && (bus.WriteAddr == bus.ReadAddrB)) next_b = bus.WriteData;
`endif
        // R0 reads as zero regardless of array contents or forwarding.
        if (bus.ReadAddrA == '0) next_a = '0;
        if (bus.ReadAddrB == '0) next_b = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            read_a_q <= '0;
            read_b_q <= '0;
        end else begin
            if (write_en) regs[bus.WriteAddr] <= bus.WriteData;
            read_a_q <= next_a;
            read_b_q <= next_b;
        end
    end

    assign bus.ReadDataA = read_a_q;
    assign bus.ReadDataB = read_b_q;

    alu_status_flags u_flags (
        .clk                  (clk),
        .reset                (reset),
        .flag_write           (bus.FlagWrite),
        .overflow_in          (bus.OverflowIn),
        .zero_in              (bus.ZeroIn),
        .flag_clear           (bus.FlagClear),
        .flag_zero            (bus.FlagZero),
        .flag_overflow        (bus.FlagOverflow),
        .flag_overflow_sticky (bus.FlagOverflowSticky)
    );

endmodule

// File: tb/tb_alu_reg_file.sv
// tb/tb_alu_reg_file.sv - scoreboard bench for alu_reg_file
module tb_alu_reg_file;
    import alu_pkg::*;

    typedef struct {
        logic [WIDTH-1:0] rda;
        logic [WIDTH-1:0] rdb;
        logic             fz;
        logic             fo;
        logic             fs;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    alu_reg_file_if bus ();

    alu_reg_file dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t             sb_q[$];
    int               n_assert = 0;
    int               n_fail   = 0;
    logic [WIDTH-1:0] mem [NUM_REGS];
    logic             m_fz, m_fo, m_fs;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("ReadDataA", bus.ReadDataA, e.rda);
                chk("ReadDataB", bus.ReadDataB, e.rdb);
                chk("FlagZero", {15'd0, bus.FlagZero}, {15'd0, e.fz});
                chk("FlagOverflow", {15'd0, bus.FlagOverflow}, {15'd0, e.fo});
                chk("FlagOverflowSticky", {15'd0, bus.FlagOverflowSticky}, {15'd0, e.fs});
            end
        end
    end

    function automatic logic [WIDTH-1:0] model_read(input logic [ADDR_W-1:0] ra, input logic we,
                                                   input logic [ADDR_W-1:0] wa, input logic [WIDTH-1:0] wd);
        if (ra == 0) return '0;
`ifdef ALU_REGFILE_BYPASS_EN
        if (we && wa == ra) return wd;
`endif
        return mem[ra];
    endfunction

    // One clock cycle of stimulus; the expected post-edge state is queued for the monitor.
    task automatic cyc(input logic rst, input logic we, input logic [ADDR_W-1:0] wa, input logic [WIDTH-1:0] wd,
                       input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb,
                       input logic fw, input logic ov, input logic zi, input logic fc);
        exp_t e;
        @(negedge clk);
        reset = rst;
        bus.RegWrite = we; bus.WriteAddr = wa; bus.WriteData = wd;
        bus.ReadAddrA = ra; bus.ReadAddrB = rb;
        bus.FlagWrite = fw; bus.OverflowIn = ov; bus.ZeroIn = zi; bus.FlagClear = fc;
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] = '0;
            m_fz = 0; m_fo = 0; m_fs = 0;
            e.rda = '0; e.rdb = '0;
        end else begin
            e.rda = model_read(ra, we, wa, wd);
            e.rdb = model_read(rb, we, wa, wd);
            if (we && wa != 0) mem[wa] = wd;
            m_fs = (m_fs && !fc) || (fw && ov);
            if (fw) begin m_fz = zi; m_fo = ov; end
        end
        e.fz = m_fz; e.fo = m_fo; e.fs = m_fs;
        sb_q.push_back(e);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb);
        cyc(0, 0, 0, 0, ra, rb, 0, 0, 0, 0);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] wa, input logic [WIDTH-1:0] wd);
        cyc(0, 1, wa, wd, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : stimulus
        int wait_cnt;
        bus.RegWrite = 0; bus.WriteAddr = 0; bus.WriteData = 0;
        bus.ReadAddrA = 0; bus.ReadAddrB = 0;
        bus.FlagWrite = 0; bus.OverflowIn = 0; bus.ZeroIn = 0; bus.FlagClear = 0;
        for (int i = 0; i < NUM_REGS; i++) mem[i] = '0;
        m_fz = 0; m_fo = 0; m_fs = 0;

        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        wr(3, 16'h1234);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        cyc(1, 0, 0, 0, 3, 3, 0, 0, 0, 0);
        for (int i = 0; i < NUM_REGS; i++) rd(i[ADDR_W-1:0], 3'(NUM_REGS - 1 - i));

        wr(1, 16'h0001);
        wr(2, 16'h0002);
        rd(1, 2);

        wr(0, 16'hFFFF);
        rd(0, 0);

        wr(5, 16'h00AA);
        cyc(0, 1, 5, 16'h0055, 5, 5, 0, 0, 0, 0);
        rd(5, 5);

        cyc(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        wr(4, 16'h1111);
        cyc(1, 1, 4, 16'h0BAD, 4, 4, 0, 0, 0, 0);
        rd(4, 4);

        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(31) == 0), ($urandom_range(1) == 1),
                3'($urandom_range(7)), 16'($urandom), 3'($urandom_range(7)), 3'($urandom_range(7)),
                ($urandom_range(1) == 1), ($urandom_range(1) == 1), ($urandom_range(1) == 1),
                ($urandom_range(3) == 0));
        end
        for (int i = 0; i < NUM_REGS; i++) rd(i[ADDR_W-1:0], i[ADDR_W-1:0]);

        wait_cnt = 0;
        while (sb_q.size() != 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        @(negedge clk);
        n_assert++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
